decode_stage_pipe: RTL and testbench

- Parametrised successor of the single-cycle decode: a registered decode stage with valid/ready handshakes on both sides.
- Adds a load-use scoreboard that stalls issue until pending loads write back, a flush input, and a parametrised stack-pointer register.
- Sits between fetch and execute. The register file stays external; this block drives its read addresses and samples its read data.

---
 rtl/decode_pkg.sv | 94 +++++++++
 rtl/decode_stage_pipe_if.sv | 33 +++
 rtl/decode_scoreboard.sv | 72 +++++++
 rtl/decode_stage_pipe.sv | 136 +++++++++++++
 tb/tb_decode_stage_pipe.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Decode control bundle, opcode map and the opcode-to-control decoder shared by the decode stage.
// Pure combinational helpers; no state, no latency, no handshake.
package decode_pkg;

    typedef struct packed {
        logic       wen;
        logic [1:0] reg0_sel;
        logic       reg1_sel;
        logic [1:0] alu_a_sel;
        logic [1:0] alu_b_sel;
        logic       b;
        logic       beq;
        logic       jmp;
        logic       ret;
        logic       mem_in_sel;
        logic       memwr;
        logic       memrd;
        logic [1:0] wb_data_sel;
        logic       wb_reg_sel;
        logic       sp_we;
        logic [1:0] imm_sel;
    } dec_ctl_t;

    localparam int CTL_W = $bits(dec_ctl_t);

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_ADDI = 5'd3;
    localparam logic [4:0] OP_LD   = 5'd4;
    localparam logic [4:0] OP_ST   = 5'd5;
    localparam logic [4:0] OP_BEQ  = 5'd6;
    localparam logic [4:0] OP_JMP  = 5'd7;
    localparam logic [4:0] OP_CALL = 5'd8;
    localparam logic [4:0] OP_RET  = 5'd9;
    localparam logic [4:0] OP_RETI = 5'd10;
    localparam logic [4:0] OP_PUSH = 5'd11;
    localparam logic [4:0] OP_POP  = 5'd12;
    localparam logic [4:0] OP_MOV  = 5'd13;

    localparam logic [1:0] SEL_RX  = 2'd0;
    localparam logic [1:0] SEL_RY  = 2'd1;
    localparam logic [1:0] SEL_LR  = 2'd2;
    localparam logic [1:0] SEL_ILR = 2'd3;

    function automatic dec_ctl_t dec_ctl(input logic [4:0] op);
        dec_ctl_t c;
        c = '0;
        case (op)
            OP_ADD:  begin c.wen = 1'b1; c.reg0_sel = SEL_RY; end
            OP_SUB:  begin c.wen = 1'b1; c.reg0_sel = SEL_RY; c.alu_b_sel = 2'd3; end
            OP_ADDI: begin c.wen = 1'b1; c.reg0_sel = SEL_RY; c.alu_b_sel = 2'd1; c.imm_sel = 2'd1; end
            OP_LD:   begin
                c.wen = 1'b1; c.reg0_sel = SEL_RY; c.alu_b_sel = 2'd1; c.imm_sel = 2'd1;
                c.memrd = 1'b1; c.wb_data_sel = 2'd1;
            end
            OP_ST:   begin
                c.reg0_sel = SEL_RY; c.reg1_sel = 1'b1; c.alu_b_sel = 2'd1; c.imm_sel = 2'd1;
                c.memwr = 1'b1; c.mem_in_sel = 1'b1;
            end
            OP_BEQ:  begin
                c.reg0_sel = SEL_RX; c.b = 1'b1; c.beq = 1'b1;
                c.alu_a_sel = 2'd1; c.alu_b_sel = 2'd1; c.imm_sel = 2'd2;
            end
            OP_JMP:  begin c.b = 1'b1; c.jmp = 1'b1; c.alu_a_sel = 2'd1; c.alu_b_sel = 2'd1; c.imm_sel = 2'd3; end
            OP_CALL: begin
                c.b = 1'b1; c.jmp = 1'b1; c.wen = 1'b1; c.wb_reg_sel = 1'b1; c.wb_data_sel = 2'd2;
                c.alu_a_sel = 2'd1; c.alu_b_sel = 2'd1; c.imm_sel = 2'd3;
            end
            OP_RET:  begin c.b = 1'b1; c.ret = 1'b1; c.reg0_sel = SEL_LR; end
            OP_RETI: begin c.b = 1'b1; c.ret = 1'b1; c.reg0_sel = SEL_ILR; end
            OP_PUSH: begin c.reg0_sel = SEL_RX; c.memwr = 1'b1; c.sp_we = 1'b1; c.alu_a_sel = 2'd2; c.alu_b_sel = 2'd2; end
            OP_POP:  begin
                c.wen = 1'b1; c.memrd = 1'b1; c.sp_we = 1'b1; c.wb_data_sel = 2'd1;
                c.alu_a_sel = 2'd2; c.alu_b_sel = 2'd2;
            end
            OP_MOV:  begin c.wen = 1'b1; c.reg0_sel = SEL_RY; c.alu_b_sel = 2'd2; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Which register operands an opcode actually reads: {src1, src0}.
    function automatic logic [1:0] dec_srcs(input logic [4:0] op);
        logic [1:0] s;
        case (op)
            OP_ADD, OP_SUB, OP_ST, OP_BEQ:                       s = 2'b11;
            OP_ADDI, OP_LD, OP_RET, OP_RETI, OP_PUSH, OP_MOV:    s = 2'b01;
            default:                                             s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side valid/ready bundles of the decode stage; slave is the stage, master the environment.
// Wires only; no latency; backpressure carried by in_ready/out_ready.
interface decode_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    import decode_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [DATA_W-1:0] in_pc;

    logic              out_valid;
    logic              out_ready;
    dec_ctl_t          out_ctl;
    logic [DATA_W-1:0] out_r0;
    logic [DATA_W-1:0] out_r1;
    logic [AW-1:0]     out_dst;
    logic [DATA_W-1:0] out_pc;
    logic [31:0]       out_inst;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_ctl, out_r0, out_r1, out_dst, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_ctl, out_r0, out_r1, out_dst, out_pc, out_inst
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Pending-load scoreboard with sticky error on an unmatched writeback; DECODE_SB_COUNT_EN selects 2-bit counts.
// State updates next cycle; busy/sat already reflect this cycle's clear so a writeback unblocks issue at once.
module decode_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [AW-1:0]   set_reg,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_reg,
    output logic [NREG-1:0] busy,
    output logic [NREG-1:0] sat,
    output logic            sb_err
);

    logic [NREG-1:0] live;

    for (genvar i = 0; i < NREG; i++) begin : g_ent
        logic set_i;
        logic clr_i;
        logic drop_i;

        assign set_i  = set_en && (set_reg == AW'(i));
        assign clr_i  = clr_en && (clr_reg == AW'(i));
        assign drop_i = clr_i && !set_i;

`ifdef DECODE_SB_COUNT_EN
        logic [1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= 2'd0;
            end else if (set_i && !clr_i && cnt != 2'd3) begin
                cnt <= cnt + 2'd1;
            end else if (drop_i && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
        end

        assign live[i] = (cnt != 2'd0);
        assign busy[i] = drop_i ? (cnt > 2'd1) : live[i];
        assign sat[i]  = !drop_i && (cnt == 2'd3);
`else
        logic ent;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ent <= 1'b0;
            end else if (set_i) begin
                ent <= 1'b1;
            end else if (clr_i) begin
                ent <= 1'b0;
            end
        end

        assign live[i] = ent;
        assign busy[i] = ent && !drop_i;
        assign sat[i]  = busy[i];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (clr_en && !live[clr_reg]) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage with load-use scoreboard, flush and SP register; DECODE_SB_COUNT_EN picks counting scoreboard.
// Latency 1 cycle; in_ready drops on flush, load-use/WAW hazard, or a held output register.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                NREG     = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(32'h0000_3000),
    parameter int                LR_IDX   = NREG - 2,
    parameter int                ILR_IDX  = NREG - 1,
    localparam int               AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_stage_pipe_if.slave  pipe,
    output logic [AW-1:0]       rf_raddr0,
    output logic [AW-1:0]       rf_raddr1,
    input  logic [DATA_W-1:0]   rf_rdata0,
    input  logic [DATA_W-1:0]   rf_rdata1,
    input  logic                ld_done_valid,
    input  logic [AW-1:0]       ld_done_reg,
    input  logic                flush,
    input  logic                sp_we,
    input  logic [DATA_W-1:0]   sp_wdata,
    output logic [DATA_W-1:0]   sp_out,
    output logic                sb_err
);

    dec_ctl_t          ctl;
    logic [1:0]        srcs;
    logic [AW-1:0]     rx, ry, rz, src0, src1;
    logic              use0, use1, is_load, hazard, issue, sb_set;
    logic [NREG-1:0]   busy, sat;

    logic              vld_q;
    dec_ctl_t          ctl_q;
    logic [DATA_W-1:0] r0_q, r1_q, pc_q;
    logic [AW-1:0]     dst_q;
    logic [31:0]       inst_q;

    assign ctl  = dec_ctl(pipe.in_inst[31:27]);
    assign srcs = dec_srcs(pipe.in_inst[31:27]);
    assign rx   = AW'(pipe.in_inst[26:22]);
    assign ry   = AW'(pipe.in_inst[21:17]);
    assign rz   = AW'(pipe.in_inst[16:12]);

    always_comb begin
        src0 = rx;
        case (ctl.reg0_sel)
            SEL_RY:  src0 = ry;
            SEL_LR:  src0 = AW'(LR_IDX);
            SEL_ILR: src0 = AW'(ILR_IDX);
            default: src0 = rx;
        endcase
    end

    assign src1      = ctl.reg1_sel ? rx : rz;
    assign rf_raddr0 = src0;
    assign rf_raddr1 = src1;

    // r0 is hardwired and never tracked, so it is never a dependency.
    assign use0    = srcs[0] && (src0 != '0);
    assign use1    = srcs[1] && (src1 != '0);
    assign is_load = ctl.memrd && ctl.wen;

    // A load sitting in the output register is not yet in the scoreboard, so compare against it directly.
    assign hazard = (use0 && busy[src0]) || (use1 && busy[src1])
                 || (vld_q && ctl_q.memrd && ((use0 && dst_q == src0) || (use1 && dst_q == src1)))
                 || (is_load && sat[rx]);

    assign pipe.in_ready = !flush && !hazard && (!vld_q || pipe.out_ready);
    assign issue         = pipe.in_valid && pipe.in_ready;

    // Loads are marked busy only once execute takes them, so a flushed load leaves no trace.
    assign sb_set = vld_q && pipe.out_ready && !flush && ctl_q.memrd && ctl_q.wen && (dst_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ctl_q  <= '0;
            r0_q   <= '0;
            r1_q   <= '0;
            dst_q  <= '0;
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            if (flush) begin
                vld_q <= 1'b0;
            end else if (issue) begin
                vld_q <= 1'b1;
            end else if (pipe.out_ready) begin
                vld_q <= 1'b0;
            end
            if (issue) begin
                ctl_q  <= ctl;
                r0_q   <= rf_rdata0;
                r1_q   <= rf_rdata1;
                dst_q  <= rx;
                pc_q   <= pipe.in_pc;
                inst_q <= pipe.in_inst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_out <= SP_RESET;
        end else if (sp_we) begin
            sp_out <= sp_wdata;
        end
    end

    decode_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (sb_set),
        .set_reg (dst_q),
        .clr_en  (ld_done_valid),
        .clr_reg (ld_done_reg),
        .busy    (busy),
        .sat     (sat),
        .sb_err  (sb_err)
    );

    assign pipe.out_valid = vld_q;
    assign pipe.out_ctl   = ctl_q;
    assign pipe.out_r0    = r0_q;
    assign pipe.out_r1    = r1_q;
    assign pipe.out_dst   = dst_q;
    assign pipe.out_pc    = pc_q;
    assign pipe.out_inst  = inst_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe with a write-first register file model driven by ld_done.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rf_raddr0, rf_raddr1;
    logic [31:0] rf_rdata0, rf_rdata1;
    logic        ld_done_valid;
    logic [4:0]  ld_done_reg;
    logic [31:0] ld_wdata;
    logic        flush;
    logic        sp_we;
    logic [31:0] sp_wdata;
    logic [31:0] sp_out;
    logic        sb_err;

    int n_chk = 0;
    int n_err = 0;

    decode_stage_pipe_if #(.DATA_W(32), .AW(5)) pipe ();

    decode_stage_pipe #(.DATA_W(32), .NREG(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe          (pipe),
        .rf_raddr0     (rf_raddr0),
        .rf_raddr1     (rf_raddr1),
        .rf_rdata0     (rf_rdata0),
        .rf_rdata1     (rf_rdata1),
        .ld_done_valid (ld_done_valid),
        .ld_done_reg   (ld_done_reg),
        .flush         (flush),
        .sp_we         (sp_we),
        .sp_wdata      (sp_wdata),
        .sp_out        (sp_out),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: unwritten entries read 0x1000+index; a writeback is visible in its own cycle.
    logic [31:0] rf_mem [32];
    logic [31:0] rf_wr = '0;

    always @(posedge clk) begin
        if (ld_done_valid) begin
            rf_mem[ld_done_reg] <= ld_wdata;
            rf_wr[ld_done_reg]  <= 1'b1;
        end
    end

    assign rf_rdata0 = (ld_done_valid && ld_done_reg == rf_raddr0) ? ld_wdata
                     : (rf_wr[rf_raddr0] ? rf_mem[rf_raddr0] : 32'h1000 + 32'(rf_raddr0));
    assign rf_rdata1 = (ld_done_valid && ld_done_reg == rf_raddr1) ? ld_wdata
                     : (rf_wr[rf_raddr1] ? rf_mem[rf_raddr1] : 32'h1000 + 32'(rf_raddr1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input int rx, input int ry, input int rz);
        return {op, 5'(rx), 5'(ry), 5'(rz), 12'h000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        pipe.in_valid = 1'b1;
        pipe.in_inst  = inst;
        pipe.in_pc    = pc;
    endtask

    task automatic idle();
        pipe.in_valid = 1'b0;
    endtask

    task automatic done(input int r, input logic [31:0] d);
        ld_done_valid = 1'b1;
        ld_done_reg   = 5'(r);
        ld_wdata      = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; sp_we = 1'b0; sp_wdata = '0;
        ld_done_valid = 1'b0; ld_done_reg = '0; ld_wdata = '0;
        pipe.in_valid = 1'b0; pipe.in_inst = '0; pipe.in_pc = '0; pipe.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rst_sp", sp_out, 32'h3000);
        check("rst_vld", 32'(pipe.out_valid), 0);
        check("rst_err", 32'(sb_err), 0);
        check("rst_r0", pipe.out_r0, 0);

        sp_we = 1'b1; sp_wdata = 32'h2FFC;
        step(); sp_we = 1'b0; #1;
        check("sp_wr", sp_out, 32'h2FFC);
        step();
        check("sp_hold", sp_out, 32'h2FFC);

        // Back-to-back independent instructions
        pipe.out_ready = 1'b1;
        present(mk(OP_ADD, 1, 2, 3), 32'h100); #1;
        check("a_rdy", 32'(pipe.in_ready), 1);
        step(); present(mk(OP_ADD, 4, 2, 3), 32'h104); #1;
        check("a_vld0", 32'(pipe.out_valid), 1);
        check("a_pc0", pipe.out_pc, 32'h100);
        check("a_r0", pipe.out_r0, 32'h1002);
        check("a_r1", pipe.out_r1, 32'h1003);
        check("a_dst0", 32'(pipe.out_dst), 1);
        check("a_wen", 32'(pipe.out_ctl.wen), 1);
        check("a_rdy1", 32'(pipe.in_ready), 1);
        step(); present(mk(OP_ADD, 6, 7, 8), 32'h108); #1;
        check("a_pc1", pipe.out_pc, 32'h104);
        step(); idle(); #1;
        check("a_pc2", pipe.out_pc, 32'h108);
        check("a_dst2", 32'(pipe.out_dst), 6);
        step();
        check("a_drain", 32'(pipe.out_valid), 0);

        // Load-use stall released by a same-cycle writeback
        present(mk(OP_LD, 5, 2, 0), 32'h200); #1;
        check("b_rdy", 32'(pipe.in_ready), 1);
        step(); present(mk(OP_ADD, 9, 5, 0), 32'h204); #1;
        check("b_memrd", 32'(pipe.out_ctl.memrd), 1);
        check("b_outreg_stall", 32'(pipe.in_ready), 0);
        step();
        check("b_sb_stall", 32'(pipe.in_ready), 0);
        check("b_vld_drop", 32'(pipe.out_valid), 0);
        step();
        check("b_hold", 32'(pipe.in_ready), 0);
        done(5, 32'hCAFE_0005); #1;
        check("b_clr_rdy", 32'(pipe.in_ready), 1);
        step(); ld_done_valid = 1'b0; idle(); #1;
        check("b_vld", 32'(pipe.out_valid), 1);
        check("b_pc", pipe.out_pc, 32'h204);
        check("b_bypass", pipe.out_r0, 32'hCAFE_0005);
        check("b_err", 32'(sb_err), 0);
        step();

        // Flushed load never marks its destination busy
        pipe.out_ready = 1'b0;
        present(mk(OP_LD, 5, 2, 0), 32'h300); #1;
        check("c_rdy", 32'(pipe.in_ready), 1);
        step(); present(mk(OP_ADD, 9, 5, 0), 32'h304); #1;
        check("c_vld", 32'(pipe.out_valid), 1);
        check("c_stall", 32'(pipe.in_ready), 0);
        step();
        check("c_hold", 32'(pipe.in_ready), 0);
        flush = 1'b1; pipe.out_ready = 1'b1; #1;
        check("c_flush_rdy", 32'(pipe.in_ready), 0);
        step(); flush = 1'b0; pipe.out_ready = 1'b0; #1;
        check("c_flush_vld", 32'(pipe.out_valid), 0);
        check("c_free", 32'(pipe.in_ready), 1);
        step(); idle(); #1;
        check("c_vld2", 32'(pipe.out_valid), 1);
        check("c_pc2", pipe.out_pc, 32'h304);
        check("c_r0", pipe.out_r0, 32'hCAFE_0005);
        pipe.out_ready = 1'b1;
        step();
        check("c_drain", 32'(pipe.out_valid), 0);

        // Two loads to r3
        present(mk(OP_LD, 3, 2, 0), 32'h400);
        step(); idle();
        step();
        present(mk(OP_LD, 3, 4, 0), 32'h404); #1;
`ifdef DECODE_SB_COUNT_EN
        check("d_waw_pass", 32'(pipe.in_ready), 1);
        step(); idle(); #1;
        check("d_ld2_vld", 32'(pipe.out_valid), 1);
        check("d_ld2_pc", pipe.out_pc, 32'h404);
        step();
        present(mk(OP_ADD, 10, 3, 0), 32'h408); #1;
        check("d_use_stall", 32'(pipe.in_ready), 0);
        done(3, 32'hD00D_0003); #1;
        check("d_cnt1", 32'(pipe.in_ready), 0);
        step(); ld_done_valid = 1'b0; #1;
        check("d_cnt1_hold", 32'(pipe.in_ready), 0);
        done(3, 32'hD00D_0033); #1;
        check("d_cnt0", 32'(pipe.in_ready), 1);
        step(); ld_done_valid = 1'b0; idle(); #1;
`else
        check("d_waw_stall", 32'(pipe.in_ready), 0);
        step();
        check("d_waw_hold", 32'(pipe.in_ready), 0);
        done(3, 32'hD00D_0003); #1;
        check("d_waw_free", 32'(pipe.in_ready), 1);
        step(); ld_done_valid = 1'b0; idle(); #1;
        check("d_ld2_vld", 32'(pipe.out_valid), 1);
        check("d_ld2_pc", pipe.out_pc, 32'h404);
        step();
        present(mk(OP_ADD, 10, 3, 0), 32'h408); #1;
        check("d_use_stall", 32'(pipe.in_ready), 0);
        done(3, 32'hD00D_0033); #1;
        check("d_use_free", 32'(pipe.in_ready), 1);
        step(); ld_done_valid = 1'b0; idle(); #1;
`endif
        check("d_pc", pipe.out_pc, 32'h408);
        check("d_r0", pipe.out_r0, 32'hD00D_0033);
        check("d_err", 32'(sb_err), 0);
        step();

        // Operand address selection
        pipe.in_inst = mk(OP_RET, 0, 0, 0); #1;
        check("f_lr", 32'(rf_raddr0), 30);
        pipe.in_inst = mk(OP_RETI, 0, 0, 0); #1;
        check("f_ilr", 32'(rf_raddr0), 31);
        pipe.in_inst = mk(OP_ST, 7, 2, 0); #1;
        check("f_st0", 32'(rf_raddr0), 2);
        check("f_st1", 32'(rf_raddr1), 7);

        // Writeback for an idle register
        done(7, 32'h7777_7777); #1;
        check("e_err_pre", 32'(sb_err), 0);
        step(); ld_done_valid = 1'b0; #1;
        check("e_err", 32'(sb_err), 1);
        step(); step();
        check("e_err_sticky", 32'(sb_err), 1);

        // Reset mid-operation
        pipe.out_ready = 1'b0;
        present(mk(OP_ADD, 1, 2, 3), 32'h500);
        step(); idle(); #1;
        check("g_vld", 32'(pipe.out_valid), 1);
        rst_n = 1'b0; #1;
        check("g_rst_vld", 32'(pipe.out_valid), 0);
        check("g_rst_pc", pipe.out_pc, 0);
        check("g_rst_err", 32'(sb_err), 0);
        check("g_rst_sp", sp_out, 32'h3000);
        step(); rst_n = 1'b1; #1;
        done(9, 32'h9999_9999);
        step(); ld_done_valid = 1'b0; #1;
        check("g_late_done_err", 32'(sb_err), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
